// File: rtl/datapath_fsm_alu_pkg.sv
// Shared constants for the operand datapath: operation modes and controller state encoding.
package datapath_pkg;

   localparam logic [1:0] MODE_CAT = 2'b00;
   localparam logic [1:0] MODE_ADD = 2'b01;
   localparam logic [1:0] MODE_SUB = 2'b10;
   localparam logic [1:0] MODE_MUL = 2'b11;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_EXEC = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   typedef enum logic [1:0] {
      IDLE = ST_IDLE,
      EXEC = ST_EXEC,
      DONE = ST_DONE
   } state_e;

endpackage

// File: rtl/datapath_fsm_alu_if.sv
// Request/result bus between the control path and the operand datapath.
interface datapath_fsm_alu_if #(
   parameter int W = 4
) ();

   logic           start;
   logic [1:0]     mode;
   logic [W-1:0]   a;
   logic [W-1:0]   b;
   logic           busy;
   logic           done;
   logic [2*W-1:0] result;

   modport master (output start, mode, a, b, input busy, done, result);
   modport slave  (input start, mode, a, b, output busy, done, result);

endinterface

// File: rtl/datapath_fsm_mul.sv
// Shift-add multiply slice: one partial product per step, W steps per operation.
module datapath_fsm_mul #(
   parameter int W = 4
) (
   input  logic           clk,
   input  logic           clr_n,
   input  logic           load,
   input  logic           step,
   input  logic [W-1:0]   a,
   input  logic [W-1:0]   b,
   output logic           last,
   output logic [2*W-1:0] product
);

   localparam int CW = $clog2(W + 1);

   logic [2*W-1:0] mcand_q, mcand_d;
   logic [2*W-1:0] acc_q, acc_d;
   logic [W-1:0]   mplier_q, mplier_d;
   logic [CW-1:0]  cnt_q, cnt_d;

   // NOTE: every _d starts as a copy of its _q, so no path through this block can infer a latch.
   always_comb begin
      mcand_d  = mcand_q;
      acc_d    = acc_q;
      mplier_d = mplier_q;
      cnt_d    = cnt_q;
      if (load) begin
         mcand_d  = {{W{1'b0}}, a};
         mplier_d = b;
         acc_d    = '0;
         cnt_d    = CW'(W);
      end else if (step && cnt_q != '0) begin
         if (mplier_q[0]) acc_d = acc_q + mcand_q;
         mcand_d  = mcand_q << 1;
         mplier_d = mplier_q >> 1;
         cnt_d    = cnt_q - CW'(1);
      end
   end

   // The step taken while last is high is the final one; product already includes it.
   assign last    = (cnt_q == CW'(1));
   assign product = acc_d;

   always_ff @(posedge clk) begin
      if (!clr_n) begin
         mcand_q  <= '0;
         acc_q    <= '0;
         mplier_q <= '0;
         cnt_q    <= '0;
      end else begin
         mcand_q  <= mcand_d;
         acc_q    <= acc_d;
         mplier_q <= mplier_d;
         cnt_q    <= cnt_d;
      end
   end

endmodule

// File: rtl/datapath_fsm_alu.sv
// Controller FSM plus datapath: concat/add/sub in one EXEC cycle, multiply over W cycles.
module datapath_fsm_alu
   import datapath_pkg::*;
#(
   parameter int W = 4
) (
   input  logic              clk,
   input  logic              clr_n,
   datapath_fsm_alu_if.slave bus
);

   state_e         state_q, state_d;
   logic [W-1:0]   a_q, a_d, b_q, b_d;
   logic [1:0]     mode_q, mode_d;
   logic           busy_q, busy_d, done_q, done_d;
   logic [2*W-1:0] result_q, result_d;
   logic [2*W-1:0] op_res, mul_product;
   logic           accept, mul_load, mul_step, mul_last;

   // A request is taken in IDLE or in DONE (back-to-back); in EXEC it is ignored.
   assign accept   = bus.start && (state_q == IDLE || state_q == DONE);
   assign mul_load = accept && (bus.mode == MODE_MUL);
   assign mul_step = (state_q == EXEC) && (mode_q == MODE_MUL);

   datapath_fsm_mul #(.W(W)) u_mul (
      .clk     (clk),
      .clr_n   (clr_n),
      .load    (mul_load),
      .step    (mul_step),
      .a       (bus.a),
      .b       (bus.b),
      .last    (mul_last),
      .product (mul_product)
   );

   always_comb begin
      case (mode_q)
         MODE_CAT: op_res = {a_q, b_q};
         MODE_ADD: op_res = {{W{1'b0}}, a_q} + {{W{1'b0}}, b_q};
         MODE_SUB: op_res = {{W{1'b0}}, a_q} - {{W{1'b0}}, b_q};
         default:  op_res = mul_product;
      endcase
   end

   always_comb begin
      state_d  = state_q;
      a_d      = a_q;
      b_d      = b_q;
      mode_d   = mode_q;
      busy_d   = 1'b0;
      done_d   = 1'b0;
      result_d = result_q;
      if (accept) begin
         a_d     = bus.a;
         b_d     = bus.b;
         mode_d  = bus.mode;
         state_d = EXEC;
         busy_d  = 1'b1;
      end else begin
         case (state_q)
            EXEC: begin
               busy_d = 1'b1;
               if (mode_q != MODE_MUL || mul_last) begin
                  result_d = op_res;
                  state_d  = DONE;
                  busy_d   = 1'b0;
                  done_d   = 1'b1;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!clr_n) begin
         state_q  <= IDLE;
         a_q      <= '0;
         b_q      <= '0;
         mode_q   <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         a_q      <= a_d;
         b_q      <= b_d;
         mode_q   <= mode_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         result_q <= result_d;
      end
   end

   assign bus.busy   = busy_q;
   assign bus.done   = done_q;
   assign bus.result = result_q;

endmodule

// File: tb/tb_datapath_fsm_alu.sv
// Scoreboard bench: driver queues expected results and completion edges, monitor checks every cycle.
module tb_datapath_fsm_alu;
   import datapath_pkg::*;

   localparam int W  = 4;
   localparam int RW = 2 * W;

   logic clk   = 1'b0;
   logic clr_n = 1'b0;

   datapath_fsm_alu_if #(.W(W)) bus ();

   datapath_fsm_alu #(.W(W)) dut (
      .clk   (clk),
      .clr_n (clr_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [RW-1:0] res;
      int            start_edge;
      int            done_edge;
   } op_t;

   op_t           sb[$];
   int            edge_cnt    = 0;
   bit            rst_seen    = 1'b1;
   int            accept_edge = 0;
   int            checks      = 0;
   int            errors      = 0;
   logic [RW-1:0] exp_res     = '0;

   always @(posedge clk) begin
      edge_cnt <= edge_cnt + 1;
      rst_seen <= !clr_n;
   end

   task automatic check(string name, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual=%0h expected=%0h edge=%0d", name, act, exp, edge_cnt);
      end
   endtask

   function automatic logic [RW-1:0] model(logic [1:0] m, logic [W-1:0] x, logic [W-1:0] y);
      longint unsigned xi = longint'(x);
      longint unsigned yi = longint'(y);
      case (m)
         MODE_CAT: return {x, y};
         MODE_ADD: return RW'(xi + yi);
         MODE_SUB: return RW'(xi - yi);
         default:  return RW'(xi * yi);
      endcase
   endfunction

   // Edges spent in EXEC before the edge that enters DONE completes.
   function automatic int exec_edges(logic [1:0] m);
      return (m == MODE_MUL) ? W : 1;
   endfunction

   // Monitor
   always @(negedge clk) begin
      if (rst_seen) begin
         while (sb.size() > 0 && sb[0].start_edge <= edge_cnt) void'(sb.pop_front());
         exp_res = '0;
         check("reset_busy", 64'(bus.busy), 64'(0));
         check("reset_done", 64'(bus.done), 64'(0));
         check("reset_result", 64'(bus.result), 64'(0));
      end else begin
         bit busy_exp, done_exp;
         while (sb.size() > 0 && sb[0].done_edge < edge_cnt) begin
            checks++;
            errors++;
            $display("FAIL done_missing: no completion at edge %0d for result %0h", sb[0].done_edge, sb[0].res);
            void'(sb.pop_front());
         end
         busy_exp = sb.size() > 0 && sb[0].start_edge <= edge_cnt && edge_cnt < sb[0].done_edge;
         done_exp = sb.size() > 0 && sb[0].done_edge == edge_cnt;
         check("busy", 64'(bus.busy), 64'(busy_exp));
         check("done", 64'(bus.done), 64'(done_exp));
         check("busy_done_excl", 64'(bus.busy && bus.done), 64'(0));
         if (done_exp) begin
            exp_res = sb[0].res;
            void'(sb.pop_front());
         end
         check("result", 64'(bus.result), 64'(exp_res));
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic junk_inputs(bit allow_start);
      bus.start = allow_start ? 1'($urandom_range(0, 1)) : 1'b0;
      bus.mode  = 2'($urandom);
      bus.a     = W'($urandom);
      bus.b     = W'($urandom);
   endtask

   task automatic issue(logic [1:0] m, logic [W-1:0] x, logic [W-1:0] y, bit junk);
      int guard = 0;
      while (edge_cnt + 1 < accept_edge) begin
         junk_inputs(junk);
         step();
         guard++;
         if (guard > 200) begin
            $display("FAIL issue_wait: accept edge %0d never reached", accept_edge);
            $fatal(1, "driver stalled");
         end
      end
      bus.start = 1'b1;
      bus.mode  = m;
      bus.a     = x;
      bus.b     = y;
      sb.push_back('{res: model(m, x, y), start_edge: edge_cnt + 1,
                     done_edge: edge_cnt + 1 + exec_edges(m)});
      accept_edge = edge_cnt + 2 + exec_edges(m);
      step();
      junk_inputs(1'b0);
   endtask

   task automatic idle(int n);
      repeat (n) begin
         junk_inputs(1'b0);
         step();
      end
   endtask

   task automatic do_reset(int n);
      clr_n = 1'b0;
      repeat (n) begin
         junk_inputs(1'b1);
         step();
      end
      clr_n       = 1'b1;
      bus.start   = 1'b0;
      accept_edge = edge_cnt + 1;
   endtask

   initial begin
      int guard;
      bus.start = 1'b0;
      bus.mode  = '0;
      bus.a     = '0;
      bus.b     = '0;

      do_reset(3);
      issue(MODE_CAT, 4'hA, 4'h5, 1'b0);
      idle(3);
      issue(MODE_ADD, 4'hF, 4'hF, 1'b0);
      issue(MODE_SUB, 4'h3, 4'h5, 1'b0);
      idle(4);
      issue(MODE_MUL, 4'hF, 4'hF, 1'b0);
      issue(MODE_CAT, 4'h1, 4'h2, 1'b1);
      idle(2);
      issue(MODE_SUB, 4'h0, 4'hF, 1'b0);
      issue(MODE_MUL, 4'h0, 4'h7, 1'b0);
      issue(MODE_MUL, 4'h9, 4'h0, 1'b1);
      idle(2);
      // Reset lands in the second EXEC cycle of a multiply.
      issue(MODE_MUL, 4'hD, 4'hB, 1'b0);
      step();
      do_reset(1);
      idle(6);

      for (int i = 0; i < 150; i++) begin
         int r = int'($urandom_range(0, 19));
         if (r == 0) do_reset(int'($urandom_range(1, 2)));
         else if (r < 5) idle(int'($urandom_range(1, 3)));
         issue(2'($urandom), W'($urandom), W'($urandom), 1'($urandom_range(0, 1)));
      end

      guard = 0;
      while (sb.size() > 0 && guard < 100) begin
         junk_inputs(1'b0);
         step();
         guard++;
      end
      if (sb.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL drain: %0d operations still outstanding", sb.size());
      end
      idle(3);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
